// File: rtl/mold_seq_ctrl_if.sv
// Header, decision and retransmit-request channels between the MoldUDP64
// receive datapath and the sequencing controller.
interface mold_seq_ctrl_if #(
  parameter int SESS_W = 80
);
  logic              hdr_valid_i;
  logic              hdr_ready_o;
  logic [SESS_W-1:0] hdr_sess_i;
  logic [63:0]       hdr_seq_i;
  logic [15:0]       hdr_cnt_i;

  logic              dec_valid_o;
  logic              dec_ready_i;
  logic              dec_keep_o;
  logic [15:0]       dec_skip_o;

  logic              gap_valid_o;
  logic              gap_ready_i;
  logic [63:0]       gap_seq_o;
  logic [15:0]       gap_cnt_o;

  logic [63:0]       expect_seq_o;
  logic              locked_o;
  logic              eos_o;
  logic              sess_err_o;

  modport master (
    output hdr_valid_i, hdr_sess_i, hdr_seq_i, hdr_cnt_i, dec_ready_i, gap_ready_i,
    input  hdr_ready_o, dec_valid_o, dec_keep_o, dec_skip_o, gap_valid_o, gap_seq_o,
           gap_cnt_o, expect_seq_o, locked_o, eos_o, sess_err_o
  );

  modport slave (
    input  hdr_valid_i, hdr_sess_i, hdr_seq_i, hdr_cnt_i, dec_ready_i, gap_ready_i,
    output hdr_ready_o, dec_valid_o, dec_keep_o, dec_skip_o, gap_valid_o, gap_seq_o,
           gap_cnt_o, expect_seq_o, locked_o, eos_o, sess_err_o
  );
endinterface

// File: rtl/mold_seq_ctrl.sv
// MoldUDP64 receive sequencing: session lock, expected-sequence tracking,
// per-packet keep/skip decision and chunked retransmit requests.
//
// state  | meaning
// IDLE   | no session locked yet
// LOCKED | session locked, packets in sequence
// GAP    | issuing retransmit request chunks
// EOS    | end of session seen, every packet dropped
module mold_seq_ctrl #(
  parameter logic [15:0] GAP_CNT_MAX = 16'd1024,
  parameter int          SESS_W      = 80
) (
  input logic            clk,
  input logic            nreset,
  mold_seq_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_EOS    = 2'd3;

  logic [1:0]        state_q;
  logic [1:0]        gap_ret_q;
  logic [SESS_W-1:0] sess_q;
  logic [63:0]       e_q;
  logic [63:0]       r_q;
  logic              out_en_q;
  logic              dec_valid_q;
  logic              keep_q;
  logic [15:0]       skip_q;
  logic              err_q;
  logic              locked_q;
  logic              eos_q;
  logic              gap_valid_q;
  logic [63:0]       gap_seq_q;
  logic [63:0]       gap_rem_q;

  logic        hdr_ready;
  logic        take;
  logic        gap_hs;
  logic [63:0] s;
  logic [15:0] n;
  logic [64:0] end65;
  logic [63:0] end64;
  logic        ovf;
  logic [63:0] e_b;
  logic [63:0] r_b;
  logic [63:0] m;
  logic [15:0] chunk;
  logic [63:0] chunk64;

  logic        d_keep;
  logic [15:0] d_skip;
  logic        d_err;
  logic [63:0] e_nxt;
  logic [63:0] r_nxt;
  logic [1:0]  st_nxt;
  logic [1:0]  g_ret;
  logic        g_start;
  logic [63:0] g_rem;
  logic        sess_ld;
  logic        eos_set;

  assign s     = bus.hdr_seq_i;
  assign n     = bus.hdr_cnt_i;
  assign end65 = {1'b0, s} + {49'd0, n};
  assign ovf   = end65[64];
  assign end64 = end65[63:0];

  // The first header seeds e and r, so it evaluates as an in-order packet.
  assign e_b = (state_q == ST_IDLE) ? s : e_q;
  assign r_b = (state_q == ST_IDLE) ? s : r_q;
  assign m   = (e_b > r_b) ? e_b : r_b;

  assign hdr_ready = out_en_q && !dec_valid_q && (state_q != ST_GAP);
  assign take      = bus.hdr_valid_i && hdr_ready;
  assign gap_hs    = gap_valid_q && bus.gap_ready_i;
  assign chunk     = (gap_rem_q > {48'd0, GAP_CNT_MAX}) ? GAP_CNT_MAX : gap_rem_q[15:0];
  assign chunk64   = {48'd0, chunk};

  always_comb begin
    d_keep  = 1'b0;
    d_skip  = '0;
    d_err   = 1'b0;
    e_nxt   = e_q;
    r_nxt   = r_q;
    st_nxt  = state_q;
    g_ret   = ST_LOCKED;
    g_start = 1'b0;
    g_rem   = '0;
    sess_ld = 1'b0;
    eos_set = 1'b0;
    if (ovf) begin
      d_err = 1'b1;
    end else if (state_q == ST_LOCKED && bus.hdr_sess_i != sess_q) begin
      d_err = 1'b1;
    end else if (state_q != ST_EOS) begin
      sess_ld = (state_q == ST_IDLE);
      e_nxt   = e_b;
      r_nxt   = r_b;
      if (n == 16'd0) begin
        if (s > m) begin
          g_start = 1'b1;
          g_rem   = s - m;
          r_nxt   = s;
        end
      end else if (n == 16'hFFFF) begin
        eos_set = 1'b1;
        g_ret   = ST_EOS;
        if (s > m) begin
          g_start = 1'b1;
          g_rem   = s - m;
          r_nxt   = s;
        end
      end else if (s == e_b) begin
        d_keep = 1'b1;
        e_nxt  = end64;
      end else if (s < e_b) begin
        // e - s < n, so the low 16 bits carry the full skip count
        if (end64 > e_b) begin
          d_keep = 1'b1;
          d_skip = e_b[15:0] - s[15:0];
          e_nxt  = end64;
        end
      end else if (end64 > m) begin
        g_start = 1'b1;
        g_rem   = end64 - m;
        r_nxt   = end64;
      end
      if (e_nxt >= r_nxt) r_nxt = e_nxt;
      st_nxt = g_start ? ST_GAP : g_ret;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      gap_ret_q   <= ST_IDLE;
      sess_q      <= '0;
      e_q         <= '0;
      r_q         <= '0;
      out_en_q    <= 1'b0;
      dec_valid_q <= 1'b0;
      keep_q      <= 1'b0;
      skip_q      <= '0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      eos_q       <= 1'b0;
      gap_valid_q <= 1'b0;
      gap_seq_q   <= '0;
      gap_rem_q   <= '0;
    end else begin
      out_en_q <= 1'b1;
      err_q    <= 1'b0;
      if (take) begin
        dec_valid_q <= 1'b1;
        keep_q      <= d_keep;
        skip_q      <= d_skip;
        err_q       <= d_err;
        e_q         <= e_nxt;
        r_q         <= r_nxt;
        state_q     <= st_nxt;
        gap_ret_q   <= g_ret;
        if (sess_ld) begin
          sess_q   <= bus.hdr_sess_i;
          locked_q <= 1'b1;
        end
        if (eos_set) eos_q <= 1'b1;
        if (g_start) begin
          gap_valid_q <= 1'b1;
          gap_seq_q   <= m;
          gap_rem_q   <= g_rem;
        end
      end else if (dec_valid_q && bus.dec_ready_i) begin
        dec_valid_q <= 1'b0;
      end
      // Remainder counts down by chunk; last chunk is the terminal count.
      if (gap_hs) begin
        gap_seq_q <= gap_seq_q + chunk64;
        gap_rem_q <= gap_rem_q - chunk64;
        if (gap_rem_q == chunk64) begin
          gap_valid_q <= 1'b0;
          state_q     <= gap_ret_q;
        end
      end
    end
  end

  assign bus.hdr_ready_o  = hdr_ready;
  assign bus.dec_valid_o  = dec_valid_q;
  assign bus.dec_keep_o   = keep_q;
  assign bus.dec_skip_o   = skip_q;
  assign bus.gap_valid_o  = gap_valid_q;
  assign bus.gap_seq_o    = gap_seq_q;
  assign bus.gap_cnt_o    = chunk;
  assign bus.expect_seq_o = e_q;
  assign bus.locked_o     = locked_q;
  assign bus.eos_o        = eos_q;
  assign bus.sess_err_o   = err_q;
endmodule

// File: tb/tb_mold_seq_ctrl.sv
// Directed bench for mold_seq_ctrl with a small chunk size so gap splitting
// shows up in a handful of requests.
module tb_mold_seq_ctrl;
  localparam logic [79:0] SESS = 80'h4d4f_4c44_5544_5036_3431;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  mold_seq_ctrl_if #(.SESS_W(80)) bus();

  mold_seq_ctrl #(.GAP_CNT_MAX(16'd4), .SESS_W(80)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  typedef struct {
    logic        bad_sess;
    logic [63:0] seq;
    logic [15:0] cnt;
    logic        keep;
    logic [15:0] skip;
    logic [63:0] e;
    logic        err;
  } vec_t;

  vec_t tbl [10];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_hdr_ready"}, bus.hdr_ready_o, 1'b0);
    chk1({tag, "_dec_valid"}, bus.dec_valid_o, 1'b0);
    chk1({tag, "_dec_keep"}, bus.dec_keep_o, 1'b0);
    chk({tag, "_dec_skip"}, 64'(bus.dec_skip_o), 64'd0);
    chk1({tag, "_gap_valid"}, bus.gap_valid_o, 1'b0);
    chk({tag, "_gap_seq"}, bus.gap_seq_o, 64'd0);
    chk({tag, "_gap_cnt"}, 64'(bus.gap_cnt_o), 64'd0);
    chk({tag, "_expect"}, bus.expect_seq_o, 64'd0);
    chk1({tag, "_locked"}, bus.locked_o, 1'b0);
    chk1({tag, "_eos"}, bus.eos_o, 1'b0);
    chk1({tag, "_sess_err"}, bus.sess_err_o, 1'b0);
  endtask

  task automatic send_hdr(input logic bad_s, input logic [63:0] sq, input logic [15:0] cn);
    int k = 0;
    while (bus.hdr_ready_o !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    if (bus.hdr_ready_o !== 1'b1) chk1("hdr_ready_timeout", bus.hdr_ready_o, 1'b1);
    bus.hdr_sess_i  = bad_s ? (SESS ^ 80'd1) : SESS;
    bus.hdr_seq_i   = sq;
    bus.hdr_cnt_i   = cn;
    bus.hdr_valid_i = 1'b1;
    tick();
    bus.hdr_valid_i = 1'b0;
  endtask

  task automatic take_dec(input string tag, input logic keep, input logic [15:0] skip,
                          input logic err);
    int k = 0;
    while (bus.dec_valid_o !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk1({tag, "_dec_valid"}, bus.dec_valid_o, 1'b1);
    chk1({tag, "_keep"}, bus.dec_keep_o, keep);
    if (keep) chk({tag, "_skip"}, 64'(bus.dec_skip_o), 64'(skip));
    chk1({tag, "_sess_err"}, bus.sess_err_o, err);
    bus.dec_ready_i = 1'b1;
    tick();
    bus.dec_ready_i = 1'b0;
    chk1({tag, "_err_pulse_end"}, bus.sess_err_o, 1'b0);
    chk1({tag, "_dec_clear"}, bus.dec_valid_o, 1'b0);
  endtask

  task automatic take_gap(input string tag, input logic [63:0] sq, input logic [15:0] cn);
    int k = 0;
    while (bus.gap_valid_o !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk1({tag, "_gap_valid"}, bus.gap_valid_o, 1'b1);
    chk({tag, "_gap_seq"}, bus.gap_seq_o, sq);
    chk({tag, "_gap_cnt"}, 64'(bus.gap_cnt_o), 64'(cn));
    bus.gap_ready_i = 1'b1;
    tick();
    bus.gap_ready_i = 1'b0;
  endtask

  task automatic run_vec(input int i);
    string tag;
    tag = $sformatf("v%0d", i);
    send_hdr(tbl[i].bad_sess, tbl[i].seq, tbl[i].cnt);
    take_dec(tag, tbl[i].keep, tbl[i].skip, tbl[i].err);
    chk({tag, "_expect"}, bus.expect_seq_o, tbl[i].e);
    chk1({tag, "_no_gap"}, bus.gap_valid_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // bad_sess, seq, cnt, keep, skip, expect after, sess_err
    tbl[0] = '{1'b0, 64'd1,   16'd3, 1'b1, 16'd0, 64'd4,   1'b0};
    tbl[1] = '{1'b0, 64'd4,   16'd2, 1'b1, 16'd0, 64'd6,   1'b0};
    tbl[2] = '{1'b0, 64'd4,   16'd5, 1'b1, 16'd2, 64'd9,   1'b0};
    tbl[3] = '{1'b0, 64'd2,   16'd3, 1'b0, 16'd0, 64'd9,   1'b0};
    tbl[4] = '{1'b0, 64'd15,  16'd2, 1'b0, 16'd0, 64'd9,   1'b0};
    tbl[5] = '{1'b0, 64'd9,   16'd8, 1'b1, 16'd0, 64'd17,  1'b0};
    tbl[6] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 16'd5, 1'b0, 16'd0, 64'd17, 1'b1};
    tbl[7] = '{1'b0, 64'd17,  16'd0, 1'b0, 16'd0, 64'd17,  1'b0};
    tbl[8] = '{1'b0, 64'd100, 16'd1, 1'b1, 16'd0, 64'd101, 1'b0};
    tbl[9] = '{1'b1, 64'd101, 16'd1, 1'b0, 16'd0, 64'd101, 1'b1};

    bus.hdr_valid_i = 1'b0;
    bus.hdr_sess_i  = '0;
    bus.hdr_seq_i   = '0;
    bus.hdr_cnt_i   = '0;
    bus.dec_ready_i = 1'b0;
    bus.gap_ready_i = 1'b0;

    #2 nreset = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) tick();
    nreset = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(i);
    chk1("locked_after_first", bus.locked_o, 1'b1);

    // Gap of 8 messages split into two chunks of 4.
    send_hdr(1'b0, 64'd15, 16'd2);
    chk1("gap_hdr_ready_lo0", bus.hdr_ready_o, 1'b0);
    take_dec("gap15", 1'b0, 16'd0, 1'b0);
    chk1("gap_hdr_ready_lo1", bus.hdr_ready_o, 1'b0);
    take_gap("gap_a", 64'd9, 16'd4);
    chk1("gap_hdr_ready_lo2", bus.hdr_ready_o, 1'b0);
    take_gap("gap_b", 64'd13, 16'd4);
    chk1("gap_done_valid", bus.gap_valid_o, 1'b0);
    chk1("gap_done_ready", bus.hdr_ready_o, 1'b1);
    chk("gap_expect", bus.expect_seq_o, 64'd9);

    for (int i = 4; i < 8; i++) run_vec(i);

    // End of session with a pending gap; gap_ready held low meanwhile.
    send_hdr(1'b0, 64'd20, 16'hFFFF);
    chk1("eos_flag", bus.eos_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk1($sformatf("hold%0d_valid", i), bus.gap_valid_o, 1'b1);
      chk($sformatf("hold%0d_seq", i), bus.gap_seq_o, 64'd17);
      chk($sformatf("hold%0d_cnt", i), 64'(bus.gap_cnt_o), 64'd3);
      if (i == 0) begin
        chk1("eos_dec_valid", bus.dec_valid_o, 1'b1);
        chk1("eos_dec_keep", bus.dec_keep_o, 1'b0);
        bus.dec_ready_i = 1'b1;
      end else begin
        bus.dec_ready_i = 1'b0;
        if (i == 1) chk1("eos_dec_done", bus.dec_valid_o, 1'b0);
      end
      tick();
    end
    bus.dec_ready_i = 1'b0;
    take_gap("eos_gap", 64'd17, 16'd3);
    chk1("eos_gap_done", bus.gap_valid_o, 1'b0);
    chk1("eos_hdr_ready", bus.hdr_ready_o, 1'b1);
    send_hdr(1'b0, 64'd17, 16'd1);
    take_dec("eos_drop", 1'b0, 16'd0, 1'b0);
    chk("eos_drop_expect", bus.expect_seq_o, 64'd17);
    chk1("eos_drop_no_gap", bus.gap_valid_o, 1'b0);
    chk1("eos_sticky", bus.eos_o, 1'b1);

    nreset = 1'b0;
    tick();
    chk1("rst_locked", bus.locked_o, 1'b0);
    chk1("rst_eos", bus.eos_o, 1'b0);
    nreset = 1'b1;

    run_vec(8);
    run_vec(9);

    // Long gap, then reset while requests are still outstanding.
    send_hdr(1'b0, 64'd200, 16'd1);
    take_dec("far", 1'b0, 16'd0, 1'b0);
    take_gap("far_a", 64'd101, 16'd4);
    chk("far_next_seq", bus.gap_seq_o, 64'd105);
    chk1("far_still_valid", bus.gap_valid_o, 1'b1);
    #2 nreset = 1'b0;
    #1;
    check_zero("mid_gap_rst");
    repeat (2) tick();
    nreset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mold_seq_ctrl.md
Name: mold_seq_ctrl

Overview:
- Sequencing controller for the MoldUDP64 receive path.
- The receiver datapath hands over one parsed packet header per packet: session, sequence number and message count.
- The block locks the session, tracks the expected sequence number and returns one keep/drop decision per packet. The decision includes how many leading messages to discard.
- On sequence gaps it schedules retransmission requests in bounded chunks toward the request transmitter.

Parameters:
- GAP_CNT_MAX, 16'd1024, maximum message count carried by one gap request.
- SESS_W, 80, session field width in bits (10 bytes).

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- hdr_valid_i  in  1  parsed header valid
- hdr_ready_o  out  1  controller can take a header
- hdr_sess_i  in  SESS_W  session of packet
- hdr_seq_i  in  64  sequence number of first message
- hdr_cnt_i  in  16  message count (0 = heartbeat, 16'hFFFF = end of session)
- dec_valid_o  out  1  decision valid
- dec_ready_i  in  1  receiver consumed decision
- dec_keep_o  out  1  1 = forward messages, 0 = drop whole packet
- dec_skip_o  out  16  leading messages to discard when dec_keep_o=1
- gap_valid_o  out  1  retransmit request valid
- gap_ready_i  in  1  request taken
- gap_seq_o  out  64  first requested sequence number
- gap_cnt_o  out  16  requested message count, range 1..GAP_CNT_MAX
- expect_seq_o  out  64  next expected sequence number
- locked_o  out  1  session locked
- eos_o  out  1  end of session seen
- sess_err_o  out  1  one-cycle pulse on session mismatch

Behaviour:
- Reset (asynchronous, nreset=0): all outputs 0. State is IDLE; e (expected), r (requested-up-to) and the session register are cleared.
- States:
  - IDLE: unlocked.
  - LOCKED: in sequence.
  - GAP: emitting requests.
  - EOS: end of session.
- hdr_ready_o = !dec_valid_o && state!=GAP. Only one header is in flight at a time.
- A header is taken on hdr_valid_i && hdr_ready_o. dec_valid_o rises the next cycle and holds its values until dec_ready_i.
- Notation: s = hdr_seq_i, n = hdr_cnt_i, end = s+n.
  - All arithmetic is unsigned 65-bit.
  - If end > 2^64-1: drop the packet and pulse sess_err_o.
- IDLE, first header:
  - Latch the session and set e = s, r = s.
  - Go to LOCKED (or EOS if n=FFFF), then evaluate as in-order.
- LOCKED, hdr_sess_i != latched session: keep=0, sess_err_o pulses. No state change.
- LOCKED, n = 1..FFFE:
  - s == e: keep=1, skip=0, e=end.
  - s < e, end <= e: duplicate, keep=0.
  - s < e, end > e: keep=1, skip=e-s, e=end.
  - s > e: keep=0. Request range is [max(e,r), end). If the range is non-empty, set r=end and go to GAP.
- Heartbeat (n=0): keep=0. If s > max(e,r), request [max(e,r), s), set r=s and go to GAP.
- End of session (n=FFFF):
  - Set eos_o=1 and keep=0.
  - If s > max(e,r), request [max(e,r), s) first. The next state after GAP is EOS, otherwise EOS directly.
- GAP:
  - Request chunk = min(remaining, GAP_CNT_MAX). gap_valid_o holds until gap_ready_i.
  - On each handshake, gap_seq_o advances by the chunk and the remainder is decremented.
  - Back to LOCKED/EOS in the cycle after the last handshake.
  - The decision for the triggering header is issued in parallel with GAP and is independent of it.
- r is not reduced when e advances: retransmitted data refills e without re-requesting. When e >= r, r tracks e.
- EOS: every header gets keep=0, with no further gap requests. Only reset leaves EOS.
- expect_seq_o = e, registered.
- Reset mid-GAP aborts the requests immediately. gap_valid_o=0 asynchronously.

Test Plan:
- Lock and in-order:
  - Stimulus: headers s=1,n=3, then s=4,n=2.
  - Required: keep=1, skip=0 for both; expect_seq_o 4 then 6; locked_o=1.
- Overlap and duplicate, after e=6:
  - Stimulus: s=4,n=5, then s=2,n=3.
  - Required: first gives keep=1, skip=2, e=9; second gives keep=0, e=9.
- Gap split with GAP_CNT_MAX=4, e=9:
  - Stimulus: s=15,n=2.
  - Required: keep=0; requests (9,4), (13,4); hdr_ready_o=0 until the second gap handshake.
  - Follow-up: repeat s=15,n=2 → no new request.
- gap_ready_i held low 5 cycles:
  - Required: gap_valid_o and gap_seq_o stable.
  - Decision handshake is independent and completes while the request is held.
- Heartbeat and EOS, e=17:
  - Stimulus: heartbeat s=17 → no request; then n=FFFF, s=20.
  - Required: request (17,3); eos_o=1; the following s=17,n=1 is dropped.
- Session mismatch and reset:
  - Stimulus: wrong session.
  - Required: keep=0, sess_err_o one-cycle pulse, e unchanged.
  - Then assert nreset low mid-GAP → all outputs 0 immediately, locked_o=0.
